// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 core types and constants
package sm83_pkg;

    typedef logic [7:0] instr_t;

    localparam instr_t OP_INSTR_16 = 8'hCB;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_HOLD = 2'd1,
        S_IMM  = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// rtl/fetch.sv - SM83 instruction fetch: PC, byte reads, CB-prefix absorption, immediates, halt
module fetch
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    output instr_t      o_instr,
    output logic        o_is_instr16,
    output logic        o_instr_valid,
    input  logic        i_next,
    input  logic        i_imm_req,
    output logic [7:0]  o_imm,
    output logic        o_imm_valid,
    input  logic        i_pc_load,
    input  logic [15:0] i_pc_value,
    input  logic        i_halt,
    input  logic        i_wake,
    output logic [15:0] o_pc
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         prefix_q, prefix_d;
    instr_t       instr_q, instr_d;
    logic         is16_q, is16_d;
    logic         valid_q, valid_d;
    logic [7:0]   imm_q, imm_d;
    logic         imm_valid_q, imm_valid_d;

    assign o_mem_req     = (state_q == S_OP) || (state_q == S_IMM);
    assign o_mem_addr    = pc_q;
    assign o_pc          = pc_q;
    assign o_instr       = instr_q;
    assign o_is_instr16  = is16_q;
    assign o_instr_valid = valid_q;
    assign o_imm         = imm_q;
    assign o_imm_valid   = imm_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        prefix_d    = prefix_q;
        instr_d     = instr_q;
        is16_d      = is16_q;
        valid_d     = valid_q;
        imm_d       = imm_q;
        imm_valid_d = 1'b0;

        if (i_pc_load) begin
            // A load overrides everything, including an ack arriving this cycle
            pc_d     = i_pc_value;
            prefix_d = 1'b0;
            valid_d  = 1'b0;
            state_d  = S_OP;
        end else begin
            unique case (state_q)
                S_OP: begin
                    if (i_mem_ack) begin
                        pc_d = pc_q + 16'd1;
                        if (i_mem_rdata == OP_INSTR_16 && !prefix_q) begin
                            prefix_d = 1'b1;
                        end else begin
                            instr_d  = i_mem_rdata;
                            is16_d   = prefix_q;
                            prefix_d = 1'b0;
                            valid_d  = 1'b1;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_next) begin
                        valid_d = 1'b0;
                        state_d = S_OP;
                    end else if (i_halt) begin
                        valid_d = 1'b0;
                        state_d = S_HALT;
                    end else if (i_imm_req) begin
                        state_d = S_IMM;
                    end
                end
                S_IMM: begin
                    if (i_mem_ack) begin
                        pc_d        = pc_q + 16'd1;
                        imm_d       = i_mem_rdata;
                        imm_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end
                S_HALT: begin
                    if (i_wake) state_d = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OP;
            pc_q        <= RESET_PC;
            prefix_q    <= 1'b0;
            instr_q     <= 8'h00;
            is16_q      <= 1'b0;
            valid_q     <= 1'b0;
            imm_q       <= 8'h00;
            imm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            prefix_q    <= prefix_d;
            instr_q     <= instr_d;
            is16_q      <= is16_d;
            valid_q     <= valid_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch with memory responder and behavioural model
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [7:0]  i_mem_rdata;
    logic [7:0]  o_instr;
    logic        o_is_instr16;
    logic        o_instr_valid;
    logic        i_next = 1'b0;
    logic        i_imm_req = 1'b0;
    logic [7:0]  o_imm;
    logic        o_imm_valid;
    logic        i_pc_load = 1'b0;
    logic [15:0] i_pc_value = 16'h0000;
    logic        i_halt = 1'b0;
    logic        i_wake = 1'b0;
    logic [15:0] o_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_instr(o_instr), .o_is_instr16(o_is_instr16), .o_instr_valid(o_instr_valid),
        .i_next(i_next), .i_imm_req(i_imm_req),
        .o_imm(o_imm), .o_imm_valid(o_imm_valid),
        .i_pc_load(i_pc_load), .i_pc_value(i_pc_value),
        .i_halt(i_halt), .i_wake(i_wake), .o_pc(o_pc)
    );

    always #5 clk = ~clk;

    // Memory responder: acks once the request has been waiting wait_cfg cycles
    logic [7:0] mem [65536];
    int wait_cfg = 0;
    int wait_cnt = 0;
    assign i_mem_ack   = o_mem_req && !rst && (wait_cnt >= wait_cfg);
    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (o_mem_req && !i_mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what the fetch stage must be doing, in terms of the instruction stream
    localparam int M_FETCH = 0, M_PRESENT = 1, M_IMM = 2, M_HALT = 3;
    int       m_mode;
    int       m_pc;
    bit       m_prefix;
    bit       m_valid;
    bit [7:0] m_instr;
    bit       m_is16;
    bit [7:0] m_imm;
    bit       m_imm_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_FETCH; m_pc = 0; m_prefix = 0; m_valid = 0;
            m_instr = 0; m_is16 = 0; m_imm = 0; m_imm_valid = 0;
        end else begin
            bit       got;
            bit [7:0] b;
            got = (m_mode == M_FETCH || m_mode == M_IMM) && i_mem_ack;
            b   = mem[m_pc];
            m_imm_valid = 0;
            if (i_pc_load) begin
                m_pc = int'(i_pc_value); m_prefix = 0; m_valid = 0; m_mode = M_FETCH;
            end else begin
                if (got) m_pc = (m_pc + 1) % 65536;
                if (m_mode == M_FETCH && got) begin
                    if (b == 8'hCB && !m_prefix) m_prefix = 1;
                    else begin
                        m_instr = b; m_is16 = m_prefix; m_prefix = 0;
                        m_valid = 1; m_mode = M_PRESENT;
                    end
                end else if (m_mode == M_IMM && got) begin
                    m_imm = b; m_imm_valid = 1; m_mode = M_PRESENT;
                end else if (m_mode == M_PRESENT) begin
                    if (i_next) begin m_valid = 0; m_mode = M_FETCH; end
                    else if (i_halt) begin m_valid = 0; m_mode = M_HALT; end
                    else if (i_imm_req) m_mode = M_IMM;
                end else if (m_mode == M_HALT && i_wake) m_mode = M_FETCH;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_pc", {16'h0, o_pc}, m_pc);
        chk("model_addr", {16'h0, o_mem_addr}, m_pc);
        chk("model_req", {31'h0, o_mem_req}, (m_mode == M_FETCH || m_mode == M_IMM));
        chk("model_valid", {31'h0, o_instr_valid}, {31'h0, m_valid});
        chk("model_imm_valid", {31'h0, o_imm_valid}, {31'h0, m_imm_valid});
        if (m_valid) begin
            chk("model_instr", {24'h0, o_instr}, {24'h0, m_instr});
            chk("model_is16", {31'h0, o_is_instr16}, {31'h0, m_is16});
        end
        if (m_imm_valid) chk("model_imm", {24'h0, o_imm}, {24'h0, m_imm});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_instr_valid && n < 50) begin tick(); n++; end
        chk({name, "_timeout"}, {31'h0, o_instr_valid}, 32'd1);
    endtask

    task automatic wait_imm(input string name);
        int n = 0;
        while (!o_imm_valid && n < 50) begin tick(); n++; end
        chk({name, "_timeout"}, {31'h0, o_imm_valid}, 32'd1);
    endtask

    task automatic pulse_next;
        i_next = 1'b1; tick(); i_next = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        i_pc_load = 1'b1; i_pc_value = v; tick(); i_pc_load = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h42;
        mem[16'h0010] = 8'hCB; mem[16'h0011] = 8'h37; mem[16'h0012] = 8'h06;
        mem[16'h0020] = 8'hCB; mem[16'h0021] = 8'h11;
        mem[16'hC000] = 8'hAF; mem[16'h0040] = 8'hC9;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("rst_pc", {16'h0, o_pc}, 32'h0000);
        chk("rst_instr", {24'h0, o_instr}, 32'h00);
        chk("rst_imm", {24'h0, o_imm}, 32'h00);
        chk("rst_imm_valid", {31'h0, o_imm_valid}, 32'd0);
        rst = 1'b0;

        // Plain opcode with one immediate
        wait_valid("op3e");
        chk("op3e_instr", {24'h0, o_instr}, 32'h3E);
        chk("op3e_is16", {31'h0, o_is_instr16}, 32'd0);
        chk("op3e_pc", {16'h0, o_pc}, 32'h0001);
        i_imm_req = 1'b1; tick(); i_imm_req = 1'b0;
        wait_imm("imm42");
        chk("imm42_val", {24'h0, o_imm}, 32'h42);
        chk("imm42_pc", {16'h0, o_pc}, 32'h0002);
        chk("imm42_hold_valid", {31'h0, o_instr_valid}, 32'd1);
        pulse_next();
        chk("next_req", {31'h0, o_mem_req}, 32'd1);
        chk("next_addr", {16'h0, o_mem_addr}, 32'h0002);
        wait_valid("op00");

        // CB prefix absorbed
        pulse_load(16'h0010);
        wait_valid("cb37");
        chk("cb37_instr", {24'h0, o_instr}, 32'h37);
        chk("cb37_is16", {31'h0, o_is_instr16}, 32'd1);
        chk("cb37_pc", {16'h0, o_pc}, 32'h0012);

        // Three wait states: request held four cycles at a stable address
        wait_cfg = 3;
        pulse_next();
        cnt = 0;
        for (int n = 0; n < 20 && !o_instr_valid; n++) begin
            if (o_mem_req && o_mem_addr == 16'h0012) cnt++;
            tick();
        end
        chk("wait_req_cycles", cnt, 32'd4);
        chk("wait_instr", {24'h0, o_instr}, 32'h06);
        chk("wait_pc", {16'h0, o_pc}, 32'h0013);
        wait_cfg = 0;

        // Load coinciding with an ack after a CB byte: ack dropped, prefix cleared
        pulse_load(16'h0020);
        tick();
        pulse_load(16'hC000);
        chk("load_drop_pc", {16'h0, o_pc}, 32'hC000);
        chk("load_drop_valid", {31'h0, o_instr_valid}, 32'd0);
        wait_valid("loadaf");
        chk("loadaf_instr", {24'h0, o_instr}, 32'hAF);
        chk("loadaf_is16", {31'h0, o_is_instr16}, 32'd0);
        chk("loadaf_pc", {16'h0, o_pc}, 32'hC001);

        // PC wrap
        pulse_load(16'hFFFF);
        wait_valid("wrap");
        chk("wrap_pc", {16'h0, o_pc}, 32'h0000);

        // Halt with a coincident wake: halt wins, no requests until woken
        i_halt = 1'b1; i_wake = 1'b1; tick(); i_halt = 1'b0; i_wake = 1'b0;
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (o_mem_req) cnt++;
            tick();
        end
        chk("halt_no_req", cnt, 32'd0);
        chk("halt_pc", {16'h0, o_pc}, 32'h0000);
        i_wake = 1'b1; tick(); i_wake = 1'b0;
        chk("wake_req", {31'h0, o_mem_req}, 32'd1);
        chk("wake_addr", {16'h0, o_mem_addr}, 32'h0000);
        wait_valid("wake3e");
        chk("wake3e_instr", {24'h0, o_instr}, 32'h3E);

        // Halt left via PC load
        i_halt = 1'b1; tick(); i_halt = 1'b0;
        tick(); tick();
        pulse_load(16'h0040);
        chk("irq_req", {31'h0, o_mem_req}, 32'd1);
        chk("irq_addr", {16'h0, o_mem_addr}, 32'h0040);
        wait_valid("irqc9");
        chk("irqc9_instr", {24'h0, o_instr}, 32'hC9);

        // Reset while a delayed request is in flight
        wait_cfg = 3;
        pulse_next();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_pc", {16'h0, o_pc}, 32'h0000);
        chk("midrst_valid", {31'h0, o_instr_valid}, 32'd0);
        chk("midrst_instr", {24'h0, o_instr}, 32'h00);
        tick();
        rst = 1'b0;
        wait_valid("post_rst");
        chk("post_rst_instr", {24'h0, o_instr}, 32'h3E);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the SM83 core; sits directly upstream of decode.
- Owns the program counter and issues byte reads on the memory bus.
- Absorbs the 0xCB prefix so decode receives either a plain opcode (is_instr16=0) or the CB body byte (is_instr16=1).
- Also serves operand-immediate byte fetches requested by the control unit, and supports PC load (jumps) and halt/wake.

Parameters:
RESET_PC, 16'h0000, PC value after reset.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
o_mem_req  out  1  read request; held until acknowledged
o_mem_addr  out  16  read address, always equals current PC
i_mem_ack  in  1  read completes this cycle; i_mem_rdata valid
i_mem_rdata  in  8  read data
o_instr  out  8  opcode byte to decode (instr_t)
o_is_instr16  out  1  o_instr is the byte following a 0xCB prefix
o_instr_valid  out  1  o_instr/o_is_instr16 valid and held
i_next  in  1  control consumed current instruction; fetch next
i_imm_req  in  1  fetch one immediate byte at PC (1-cycle pulse)
o_imm  out  8  immediate byte
o_imm_valid  out  1  1-cycle pulse, o_imm valid
i_pc_load  in  1  load PC (jump/call/ret/rst/interrupt)
i_pc_value  in  16  new PC
i_halt  in  1  enter halt after current instruction
i_wake  in  1  leave halt
o_pc  out  16  current PC (address of next byte to fetch)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - PC=RESET_PC, state=S_OP, prefix flag=0.
  - o_instr=8'h00, o_is_instr16=0, o_instr_valid=0, o_imm=8'h00, o_imm_valid=0.
  - Outputs are registered, except o_mem_req/o_mem_addr, which decode state and PC combinationally.
- States: S_OP (fetch opcode), S_HOLD (instruction presented), S_IMM (fetch immediate), S_HALT.
- o_mem_req=1 exactly in S_OP and S_IMM; o_mem_addr=PC always.
- Memory handshake: req stays high, address stable, until i_mem_ack. Zero-wait-state memory acks in the same cycle as req. No reads are pipelined or outstanding beyond the current cycle.
- On any accepted byte (req && ack && !i_pc_load): PC<=PC+1, wrapping 16'hFFFF->16'h0000.
- S_OP with ack:
  - If rdata==OP_INSTR_16 (0xCB) and prefix=0: prefix<=1, stay S_OP, no valid.
  - Otherwise: o_instr<=rdata, o_is_instr16<=prefix, prefix<=0, o_instr_valid<=1, go S_HOLD.
  - 0xCB fetched with prefix=1 is a CB body byte (CB CB = SET 1,E), presented with is_instr16=1.
  - Minimum latency: ack cycle -> o_instr_valid high next cycle.
- S_HOLD: o_instr/o_is_instr16 held stable, o_instr_valid=1. Priority i_next > i_halt > i_imm_req:
  - i_imm_req: go S_IMM; o_instr_valid stays 1.
  - i_next: o_instr_valid<=0, go S_OP.
  - i_halt: o_instr_valid<=0, go S_HALT.
- S_IMM with ack: o_imm<=rdata, o_imm_valid<=1 for one cycle, return S_HOLD. i_imm_req/i_next while in S_IMM are ignored; control must wait for o_imm_valid.
- S_HALT: no requests; PC frozen. i_wake goes to S_OP. i_halt/i_wake together in S_HOLD: halt wins; wake is sampled next cycle.
- i_pc_load (any state, highest priority after rst):
  - PC<=i_pc_value, prefix<=0, o_instr_valid<=0, o_imm_valid<=0, go S_OP.
  - A coincident i_mem_ack is discarded: data dropped, no PC increment.
  - In S_HALT, pc_load also wakes (interrupt dispatch).
- Reset mid-request: all state to reset values immediately; in-flight ack is ignored.
- o_pc: registered PC. During S_HOLD it is the address after the opcode, i.e. the first immediate byte.

Decomposition:
- sm83_pkg gains fetch_state_t (S_OP, S_HOLD, S_IMM, S_HALT).
- Reuses existing OP_INSTR_16 and instr_t.
- RESET_PC default lives in sm83_pkg as a localparam for top-level use.
- No sub-module; PC increment is inline. An optional pc_reg sub-module is not warranted.

Test Plan:
- Reset, memory {0x00:3E, 0x01:42}, zero-wait ack -> o_instr=3E, valid, is_instr16=0. i_imm_req -> o_imm=42 pulse, o_pc=0002. i_next -> fetch at 0002.
- Memory {0x10:CB, 0x11:37} -> single valid with o_instr=37, is_instr16=1. o_pc=0012; no valid ever shows CB.
- Ack delayed 3 cycles -> o_mem_req/o_mem_addr stable 4 cycles; PC increments exactly once.
- i_pc_load=1, i_pc_value=C000 in the same cycle as an ack in S_OP -> data discarded, next addr C000, prefix cleared (load after a CB fetch -> next opcode has is_instr16=0).
- PC=FFFF fetch -> o_pc=0000.
- i_halt in S_HOLD -> no req for 10 cycles. i_wake -> req at unchanged PC. Separately, i_pc_load=0040 in S_HALT -> req at 0040.
